// File: rtl/moore_serial_tx_if.sv
// Bundle of the frame-request and serial-output signals of moore_serial_tx.
//   master: drives start/data_in, observes x_out/busy/done/zero_count
//   slave : the transmitter side
//   start      - frame request
//   data_in    - parallel frame word, captured on accept
//   x_out      - serial data, MSB first
//   busy       - high while bits are shifted
//   done       - one-cycle pulse after the last bit
//   zero_count - number of 0 bits in the current/last frame
interface moore_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             x_out;
  logic             busy;
  logic             done;
  logic [4:0]       zero_count;

  modport master (
    output start, data_in,
    input  x_out, busy, done, zero_count
  );

  modport slave (
    input  start, data_in,
    output x_out, busy, done, zero_count
  );
endinterface

// File: rtl/moore_serial_tx.sv
// Moore serial transmitter: on an accepted start, loads a WIDTH-bit word and
// shifts it out MSB first, one bit per clock, then pulses done for one cycle.
// Also counts the 0 bits of the frame.
//   clock - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - moore_serial_tx_if slave (start, data_in, x_out, busy, done,
//           zero_count)
// Parameters: WIDTH (2..16) frame length, IDLE_LEVEL line level when idle.
module moore_serial_tx #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  moore_serial_tx_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [4:0]       zcnt_q,  zcnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      zcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      zcnt_q  <= zcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    zcnt_d  = zcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          shreg_d = bus.data_in;
          cnt_d   = '0;
          zcnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        // The bit leaving this edge is the one currently on x_out.
        if (!shreg_q[WIDTH-1]) begin
          zcnt_d = zcnt_q + 5'd1;
        end
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only, so reset clears them at once.
  always_comb begin
    bus.x_out      = IDLE_LEVEL;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.zero_count = zcnt_q;
    if (state_q == ST_SHIFT) begin
      bus.x_out = shreg_q[WIDTH-1];
      bus.busy  = 1'b1;
    end
    if (state_q == ST_DONE) begin
      bus.done = 1'b1;
    end
  end

endmodule

// File: tb/tb_moore_serial_tx.sv
module tb_moore_serial_tx;

  localparam int   WIDTH      = 8;
  localparam logic IDLE_LEVEL = 1'b0;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  moore_serial_tx_if #(.WIDTH(WIDTH)) bus ();

  moore_serial_tx #(
    .WIDTH      (WIDTH),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic       exp_bits[$];
  logic [4:0] exp_zc[$];
  int         bits_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected serial bits are the word MSB first; zc < 0 means no done pulse.
  task automatic push_frame(input logic [WIDTH-1:0] d, input int nbits, input int zc);
    for (int k = 0; k < nbits; k++) exp_bits.push_back(d[WIDTH-1-k]);
    if (zc >= 0) exp_zc.push_back(5'(zc));
  endtask

  // Returns #1 after the accept edge with start dropped.
  task automatic accept(input logic [WIDTH-1:0] d);
    @(posedge clock);
    #1 bus.start = 1'b1;
    bus.data_in = d;
    @(posedge clock);
    #1 bus.start = 1'b0;
    bus.data_in = WIDTH'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_bits.size() != 0 || exp_zc.size() != 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    check(name, (n < 200) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Monitor: samples on the falling edge, consumes the scoreboard.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      bits_seen = 0;
    end else if (bus.busy) begin
      check("done_during_busy", {31'd0, bus.done}, 32'd0);
      if (exp_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit: got busy=1 x_out=%0b, expected idle line", bus.x_out);
      end else begin
        check("x_out_bit", {31'd0, bus.x_out}, {31'd0, exp_bits.pop_front()});
      end
      bits_seen++;
    end else begin
      check("x_out_idle", {31'd0, bus.x_out}, {31'd0, IDLE_LEVEL});
      if (bus.done) begin
        if (exp_zc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no done pulse");
        end else begin
          check("zero_count", {27'd0, bus.zero_count}, {27'd0, exp_zc.pop_front()});
          check("frame_len", bits_seen, WIDTH);
        end
        bits_seen = 0;
      end
    end
  end

  initial begin
    reset       = 1'b0;
    bus.start   = 1'bx;
    bus.data_in = 'x;
    #1;
    check("rst_x_out",  {31'd0, bus.x_out}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_done",   {31'd0, bus.done},  32'd0);
    check("rst_zcount", {27'd0, bus.zero_count}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_x_out_clk",  {31'd0, bus.x_out}, 32'd0);
    check("rst_busy_clk",   {31'd0, bus.busy},  32'd0);
    check("rst_done_clk",   {31'd0, bus.done},  32'd0);
    check("rst_zcount_clk", {27'd0, bus.zero_count}, 32'd0);
    bus.start   = 1'b0;
    bus.data_in = '0;
    @(negedge clock);
    reset = 1'b1;

    // Basic frame 1,0,1,0,1,0,1,0
    push_frame(8'hAA, 8, 4);
    accept(8'hAA);
    wait_drain("drain_aa");
    check("zcount_hold_aa", {27'd0, bus.zero_count}, 32'd4);

    // Extreme words
    push_frame(8'h00, 8, 8);
    accept(8'h00);
    wait_drain("drain_00");
    check("zcount_hold_00", {27'd0, bus.zero_count}, 32'd8);
    push_frame(8'hFF, 8, 0);
    accept(8'hFF);
    wait_drain("drain_ff");

    // Start held: three back-to-back frames, 10 cycles apart
    for (int f = 0; f < 3; f++) push_frame(8'h96, 8, 4);
    @(posedge clock);
    #1 bus.start = 1'b1;
    bus.data_in = 8'h96;
    repeat (21) @(posedge clock);
    #1 bus.start = 1'b0;
    wait_drain("drain_held");

    // Start and data_in changes mid-frame are ignored
    push_frame(8'hF0, 8, 4);
    accept(8'hF0);
    repeat (2) @(posedge clock);
    #1 bus.start = 1'b1;
    bus.data_in = 8'h0F;
    @(posedge clock);
    #1 bus.start = 1'b0;
    wait_drain("drain_f0");
    repeat (12) @(posedge clock);
    #1;

    // Reset after bit 3 of 0xAA: no further bits, no done
    push_frame(8'hAA, 4, -1);
    accept(8'hAA);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, bus.busy},  32'd0);
    check("midrst_done",   {31'd0, bus.done},  32'd0);
    check("midrst_x_out",  {31'd0, bus.x_out}, 32'd0);
    check("midrst_zcount", {27'd0, bus.zero_count}, 32'd0);
    check("midrst_bits_sent", exp_bits.size(), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    push_frame(8'h55, 8, 4);
    accept(8'h55);
    wait_drain("drain_55");
    check("zcount_hold_55", {27'd0, bus.zero_count}, 32'd4);

    repeat (5) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
